// File: rtl/security_pkg.sv
// Shared command codes, LED patterns and transmitter state encoding for the WiFi command bus.
// CMD_CONFIRM_EN adds the WAIT_ACK state to the encoding.
package security_pkg;

  localparam logic [4:0] CMD_IDLE   = 5'h00;
  localparam logic [4:0] CMD_DISARM = 5'h0A;
  localparam logic [4:0] CMD_ARM    = 5'h0B;
  localparam logic [4:0] CMD_PANIC  = 5'h0E;

  localparam logic [3:0] LED_OFF    = 4'b0001;
  localparam logic [3:0] LED_ARMED  = 4'b0010;
  localparam logic [3:0] LED_ALARM  = 4'b0100;
  localparam logic [3:0] LED_EMERG  = 4'b1000;

`ifdef CMD_CONFIRM_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_ACK = 2'd3
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;
`endif

  // Larger value wins: PANIC > DISARM > ARM > nothing.
  function automatic logic [1:0] cmd_prio(input logic [4:0] code);
    case (code)
      CMD_PANIC:  cmd_prio = 2'd3;
      CMD_DISARM: cmd_prio = 2'd2;
      CMD_ARM:    cmd_prio = 2'd1;
      default:    cmd_prio = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] cmd_led(input logic [4:0] code);
    case (code)
      CMD_DISARM: cmd_led = LED_OFF;
      CMD_ARM:    cmd_led = LED_ARMED;
      CMD_PANIC:  cmd_led = LED_EMERG;
      default:    cmd_led = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: the stable flag follows the raw input once it has differed for
// DEBOUNCE_CYCLES consecutive cycles; a rising stable flag gives a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          press_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg    <= CW'(DEBOUNCE_CYCLES);
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (btn == stable_reg) begin
        cnt_reg <= CW'(DEBOUNCE_CYCLES);
      end else if (cnt_reg == CW'(1)) begin
        stable_reg <= btn;
        press_reg  <= btn;
        cnt_reg    <= CW'(DEBOUNCE_CYCLES);
      end else begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/wifi_cmd_transmitter.sv
// Keypad-to-WiFi command source: debounced presses become framed bursts on cmd_code.
// CMD_CONFIRM_EN builds the status-confirmation wait with timeout and retries.
module wifi_cmd_transmitter
  import security_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int ACK_TIMEOUT     = 16,
  parameter int MAX_RETRIES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_disarm,
  input  logic       btn_arm,
  input  logic       btn_panic,
  input  logic [3:0] sys_leds,
  output logic [4:0] cmd_code,
  output logic       cmd_valid,
  output logic       busy,
  output logic       confirmed,
  output logic       failed
);

  localparam int HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (HG_MAX > ACK_TIMEOUT) ? HG_MAX : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0] btn_vec;
  logic [2:0] press_vec;

  assign btn_vec = {btn_panic, btn_disarm, btn_arm};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clock (clock),
        .reset (reset),
        .btn   (btn_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  logic       req_valid;
  logic [4:0] req_code;

  always_comb begin
    req_valid = |press_vec;
    req_code  = CMD_IDLE;
    if (press_vec[2])      req_code = CMD_PANIC;
    else if (press_vec[1]) req_code = CMD_DISARM;
    else if (press_vec[0]) req_code = CMD_ARM;
  end

  tx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       cur_code_reg;
  logic             pend_valid_reg;
  logic [4:0]       pend_code_reg;
  logic [4:0]       cmd_code_reg;
  logic             cmd_valid_reg;
  logic             busy_reg;
  logic             store_req;

  // Only a strictly higher-priority request may replace the pending one.
  assign store_req = req_valid &&
                     (!pend_valid_reg || (cmd_prio(req_code) > cmd_prio(pend_code_reg)));

`ifdef CMD_CONFIRM_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] retry_reg;
  logic          confirmed_reg;
  logic          failed_reg;
`else
  logic unused_cfg;
  assign unused_cfg = ^{sys_leds, MAX_RETRIES};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      cur_code_reg   <= CMD_IDLE;
      pend_valid_reg <= 1'b0;
      pend_code_reg  <= CMD_IDLE;
      cmd_code_reg   <= CMD_IDLE;
      cmd_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef CMD_CONFIRM_EN
      retry_reg      <= '0;
      confirmed_reg  <= 1'b0;
      failed_reg     <= 1'b0;
`endif
    end else begin
`ifdef CMD_CONFIRM_EN
      confirmed_reg <= 1'b0;
      failed_reg    <= 1'b0;
`endif
      if (state_reg != ST_IDLE && store_req) begin
        pend_valid_reg <= 1'b1;
        pend_code_reg  <= req_code;
      end
      case (state_reg)
        ST_IDLE: begin
          if (pend_valid_reg || req_valid) begin
            state_reg     <= ST_SEND;
            busy_reg      <= 1'b1;
            cmd_valid_reg <= 1'b1;
            cnt_reg       <= CNT_W'(HOLD_CYCLES);
`ifdef CMD_CONFIRM_EN
            retry_reg     <= RW'(MAX_RETRIES);
`endif
            // The pending entry goes first; a same-cycle new request takes the freed slot.
            if (pend_valid_reg) begin
              cur_code_reg   <= pend_code_reg;
              cmd_code_reg   <= pend_code_reg;
              pend_valid_reg <= req_valid;
              pend_code_reg  <= req_code;
            end else begin
              cur_code_reg <= req_code;
              cmd_code_reg <= req_code;
            end
          end
        end
        ST_SEND: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg     <= ST_GAP;
            cmd_code_reg  <= CMD_IDLE;
            cmd_valid_reg <= 1'b0;
            cnt_reg       <= CNT_W'(GAP_CYCLES);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_reg == CNT_W'(1)) begin
`ifdef CMD_CONFIRM_EN
            state_reg <= ST_WAIT_ACK;
            cnt_reg   <= CNT_W'(ACK_TIMEOUT);
`else
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
`ifdef CMD_CONFIRM_EN
        ST_WAIT_ACK: begin
          if (sys_leds == cmd_led(cur_code_reg)) begin
            confirmed_reg <= 1'b1;
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
          end else if (pend_valid_reg && (cmd_prio(pend_code_reg) > cmd_prio(cur_code_reg))) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_W'(1)) begin
            if (retry_reg != '0) begin
              retry_reg     <= retry_reg - RW'(1);
              state_reg     <= ST_SEND;
              cmd_code_reg  <= cur_code_reg;
              cmd_valid_reg <= 1'b1;
              cnt_reg       <= CNT_W'(HOLD_CYCLES);
            end else begin
              failed_reg <= 1'b1;
              state_reg  <= ST_IDLE;
              busy_reg   <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_code  = cmd_code_reg;
  assign cmd_valid = cmd_valid_reg;
  assign busy      = busy_reg;
`ifdef CMD_CONFIRM_EN
  assign confirmed = confirmed_reg;
  assign failed    = failed_reg;
`else
  assign confirmed = 1'b0;
  assign failed    = 1'b0;
`endif

endmodule
